clock_set_ctrl: RTL

Mode controller for the BCD digital clock. It sequences the seconds/minutes/hours counter chain: it gates the 1 Hz enable in normal running and walks the user through hour and minute editing with two debounced keys. When editing ends it issues a one-cycle parallel load of the edited time. It sits between the key debouncers / tick divider and the counter chain, and also drives the display blink select.

---
 rtl/clock_set_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode controller for the BCD digital clock.
// It gates the 1 Hz run enable, sequences hour and minute editing from
// two debounced keys, and issues a one-cycle parallel load of the edited
// time to the counter chain.
// Ports:
//   clk, rst (async, active-high), tick (1 Hz enable pulse)
//   key_mode, key_inc (debounced one-cycle key pulses)
//   cur_hour/cur_min/cur_sec (BCD time from the counter chain)
//   run_en (seconds counter enable), load + load_hour/min/sec (parallel load)
//   edit_sel (display field select), blink (display blink phase), alarm
// Optional feature: define CLOCK_ALARM_EN to build the alarm setting states
// and alarm compare; otherwise alarm is tied 0.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       run_en,
    output logic       load,
    output logic [7:0] load_hour,
    output logic [7:0] load_min,
    output logic [7:0] load_sec,
    output logic [1:0] edit_sel,
    output logic       blink,
    output logic       alarm
);
    typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, LOAD, AL_HOUR, AL_MIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] shadow_hour_q, shadow_hour_d, shadow_min_q, shadow_min_d;
    logic [7:0] idle_q, idle_d;
    logic       blink_q, blink_d, edit;
    logic       unused_sec;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        return v == max ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    assign unused_sec = ^cur_sec;
    assign edit       = state_q inside {SET_HOUR, SET_MIN, AL_HOUR, AL_MIN};
    assign run_en     = state_q == RUN && tick;
    assign load       = state_q == LOAD;
    assign load_hour  = shadow_hour_q;
    assign load_min   = shadow_min_q;
    assign load_sec   = 8'h00;
    assign edit_sel   = state_q == SET_HOUR ? 2'd1 : state_q == SET_MIN ? 2'd2 :
                        state_q inside {AL_HOUR, AL_MIN} ? 2'd3 : 2'd0;
    assign blink      = blink_q;

`ifdef CLOCK_ALARM_EN
    logic [7:0] alarm_hour_q, alarm_hour_d, alarm_min_q, alarm_min_d;
    logic       arm_q, arm_d;
    assign alarm = state_q == RUN && arm_q && cur_hour == alarm_hour_q && cur_min == alarm_min_q;
`else
    assign alarm = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        shadow_hour_d = shadow_hour_q;
        shadow_min_d  = shadow_min_q;
        idle_d        = idle_q;
        blink_d       = blink_q ^ (tick & edit);
`ifdef CLOCK_ALARM_EN
        alarm_hour_d  = alarm_hour_q;
        alarm_min_d   = alarm_min_q;
        arm_d         = arm_q;
`endif
        if (state_q == RUN) begin
            if (key_mode) begin
                state_d       = SET_HOUR;
                shadow_hour_d = cur_hour;
                shadow_min_d  = cur_min;
                idle_d        = 8'd0;
            end
`ifdef CLOCK_ALARM_EN
            else if (key_inc) arm_d = 1'b0;
`endif
        end else if (state_q == LOAD) begin
            state_d = RUN;
        end else if (key_mode) begin
            // key_mode has priority over key_inc in the same cycle
            idle_d = 8'd0;
            case (state_q)
                SET_HOUR: state_d = SET_MIN;
`ifdef CLOCK_ALARM_EN
                SET_MIN:  state_d = AL_HOUR;
                AL_HOUR:  state_d = AL_MIN;
                AL_MIN: begin
                    state_d = LOAD;
                    arm_d   = 1'b1;
                end
`endif
                default:  state_d = LOAD;
            endcase
        end else if (key_inc) begin
            idle_d = 8'd0;
            case (state_q)
                SET_HOUR: shadow_hour_d = bcd_inc(shadow_hour_q, 8'h23);
                SET_MIN:  shadow_min_d  = bcd_inc(shadow_min_q, 8'h59);
`ifdef CLOCK_ALARM_EN
                AL_HOUR:  alarm_hour_d  = bcd_inc(alarm_hour_q, 8'h23);
                AL_MIN:   alarm_min_d   = bcd_inc(alarm_min_q, 8'h59);
`endif
                default: ;
            endcase
        end else if (tick) begin
            // abandon the edit without loading once the idle budget is spent
            idle_d = idle_q + 8'd1;
            if (idle_d == 8'(TIMEOUT)) begin
                state_d = RUN;
                idle_d  = 8'd0;
            end
        end
        if (state_d == RUN || state_d == LOAD) blink_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            shadow_hour_q <= 8'h00;
            shadow_min_q  <= 8'h00;
            idle_q        <= 8'd0;
            blink_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_hour_q <= shadow_hour_d;
            shadow_min_q  <= shadow_min_d;
            idle_q        <= idle_d;
            blink_q       <= blink_d;
        end
    end

`ifdef CLOCK_ALARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_hour_q <= 8'h00;
            alarm_min_q  <= 8'h00;
            arm_q        <= 1'b0;
        end else begin
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            arm_q        <= arm_d;
        end
    end
`endif
endmodule
